// File: rtl/dmem_resp.sv
// RV32I data-memory responder: one outstanding load/store over valid/ready
// channels, with programmable wait states and access-error flagging.
module dmem_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              enter_resp;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [2:0]        lat_funct3;

    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [2:0]        cur_funct3;

    logic              acc_err;
    logic [IDX_W-1:0]  widx;
    logic [31:0]       rword;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [31:0]       load_data;
    logic [3:0]        wbe;
    logic [31:0]       wword;

    logic [31:0]       mem [DEPTH_WORDS];

    wire handshake = req_valid && req_ready;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // With zero wait states the array is accessed on the accepting edge, so the
    // request is taken straight from the ports rather than from the latch.
    always_comb begin
        if (state == IDLE) begin
            cur_we     = req_we;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
            cur_funct3 = req_funct3;
        end else begin
            cur_we     = lat_we;
            cur_addr   = lat_addr;
            cur_wdata  = lat_wdata;
            cur_funct3 = lat_funct3;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        acc_err = 1'b0;
        if (cur_funct3 == 3'd3 || cur_funct3 == 3'd6 || cur_funct3 == 3'd7) acc_err = 1'b1;
        if (cur_we && cur_funct3 > 3'd2)                                    acc_err = 1'b1;
        if (cur_funct3[1:0] == 2'd1 && cur_addr[0])                         acc_err = 1'b1;
        if (cur_funct3[1:0] == 2'd2 && cur_addr[1:0] != 2'b00)              acc_err = 1'b1;
        if ({2'b00, cur_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS))          acc_err = 1'b1;
    end

    assign widx  = cur_addr[IDX_W+1:2];
    assign rword = mem[widx];
    assign rbyte = rword[8*cur_addr[1:0] +: 8];
    assign rhalf = cur_addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (cur_funct3)
            3'd0:    load_data = {{24{rbyte[7]}}, rbyte};
            3'd4:    load_data = {24'h0, rbyte};
            3'd1:    load_data = {{16{rhalf[15]}}, rhalf};
            3'd5:    load_data = {16'h0, rhalf};
            3'd2:    load_data = rword;
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        wbe   = 4'b0000;
        wword = cur_wdata;
        case (cur_funct3)
            3'd0: begin
                wbe   = 4'b0001 << cur_addr[1:0];
                wword = {4{cur_wdata[7:0]}};
            end
            3'd1: begin
                wbe   = cur_addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{cur_wdata[15:0]}};
            end
            3'd2:    wbe = 4'b1111;
            default: wbe = 4'b0000;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (handshake) begin
                lat_we     <= req_we;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                lat_funct3 <= req_funct3;
            end
            if (enter_resp) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || cur_we) ? 32'h0 : load_data;
            end
        end
    end

    // NOTE: the array has no reset branch; clearing it would turn the RAM into
    // a flop bank, and its contents are defined only by stores.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: one instance with two wait states and one with
// none, sharing the request bus; sel picks which instance is driven and observed.
module tb_dmem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        resp_ready = 1'b0;

    logic        rdy_a, rdy_b, vld_a, vld_b, err_a, err_b;
    logic [31:0] rdata_a, rdata_b;

    wire         req_ready_o  = sel ? rdy_b   : rdy_a;
    wire         resp_valid_o = sel ? vld_b   : vld_a;
    wire         resp_err_o   = sel ? err_b   : err_a;
    wire [31:0]  resp_rdata_o = sel ? rdata_b : rdata_a;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid && !sel),
        .req_ready  (rdy_a),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (vld_a),
        .resp_ready (resp_ready && !sel),
        .resp_rdata (rdata_a),
        .resp_err   (err_a)
    );

    dmem_resp #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid && sel),
        .req_ready  (rdy_b),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (vld_b),
        .resp_ready (resp_ready && sel),
        .resp_rdata (rdata_b),
        .resp_err   (err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
    endtask

    // Issues one request, waits (bounded) for the response and checks latency in
    // cycles counted from the cycle req_valid is presented, then the data/error.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_cyc);
        int lat;
        @(negedge clk);
        drive_req(we, addr, wdata, f3);
        check({tag, " req_ready"}, {31'b0, req_ready_o}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat + 1), 32'(exp_cyc));
        check({tag, " rdata"}, resp_rdata_o, exp_rdata);
        check({tag, " err"}, {31'b0, resp_err_o}, {31'b0, exp_err});
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, " idle"}, {30'b0, req_ready_o, resp_valid_o}, 32'b10);
    endtask

    initial begin
        // Reset state of the two-wait-state instance.
        #12;
        check("rst resp_valid", {31'b0, resp_valid_o}, 32'd0);
        check("rst rdata", resp_rdata_o, 32'h0);
        check("rst err", {31'b0, resp_err_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst req_ready", {31'b0, req_ready_o}, 32'd1);

        // Word store / load and sub-word loads.
        xact("sw 10",   1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0,        1'b0, 3);
        xact("lw 10",   1'b0, 32'h10, 32'h0,        3'd2, 32'hDEADBEEF, 1'b0, 3);
        xact("lb 13",   1'b0, 32'h13, 32'h0,        3'd0, 32'hFFFFFFDE, 1'b0, 3);
        xact("lbu 13",  1'b0, 32'h13, 32'h0,        3'd4, 32'h000000DE, 1'b0, 3);
        xact("lh 12",   1'b0, 32'h12, 32'h0,        3'd1, 32'hFFFFDEAD, 1'b0, 3);
        xact("lhu 10",  1'b0, 32'h10, 32'h0,        3'd5, 32'h0000BEEF, 1'b0, 3);

        // Partial stores keep the other lanes.
        xact("sb 11",   1'b1, 32'h11, 32'h12345677, 3'd0, 32'h0,        1'b0, 3);
        xact("lw sb",   1'b0, 32'h10, 32'h0,        3'd2, 32'hDEAD77EF, 1'b0, 3);
        xact("sh 12",   1'b1, 32'h12, 32'h0000CAFE, 3'd1, 32'h0,        1'b0, 3);
        xact("lw sh",   1'b0, 32'h10, 32'h0,        3'd2, 32'hCAFE77EF, 1'b0, 3);

        // Rejected accesses leave the array untouched.
        xact("lw mis",  1'b0, 32'h11,  32'h0,        3'd2, 32'h0,        1'b1, 3);
        xact("lw e1",   1'b0, 32'h10,  32'h0,        3'd2, 32'hCAFE77EF, 1'b0, 3);
        xact("sh mis",  1'b1, 32'h13,  32'hFFFFFFFF, 3'd1, 32'h0,        1'b1, 3);
        xact("lw e2",   1'b0, 32'h10,  32'h0,        3'd2, 32'hCAFE77EF, 1'b0, 3);
        xact("lw oor",  1'b0, 32'h400, 32'h0,        3'd2, 32'h0,        1'b1, 3);
        xact("lw e3",   1'b0, 32'h10,  32'h0,        3'd2, 32'hCAFE77EF, 1'b0, 3);
        xact("f3 3",    1'b1, 32'h10,  32'h0,        3'd3, 32'h0,        1'b1, 3);
        xact("lw e4",   1'b0, 32'h10,  32'h0,        3'd2, 32'hCAFE77EF, 1'b0, 3);

        // Zero-wait instance: backpressure with an ignored request held on the bus.
        sel = 1'b1;
        xact("w0 sw 8", 1'b1, 32'h8, 32'h55AA55AA, 3'd2, 32'h0, 1'b0, 1);
        @(negedge clk);
        drive_req(1'b0, 32'h8, 32'h0, 3'd2);
        @(posedge clk); #1;
        check("bp first valid", {31'b0, resp_valid_o}, 32'd1);
        drive_req(1'b1, 32'h8, 32'h0, 3'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp hold", {30'b0, resp_valid_o, req_ready_o}, 32'b10);
            check("bp rdata", resp_rdata_o, 32'h55AA55AA);
        end
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp release", {30'b0, req_ready_o, resp_valid_o}, 32'b10);
        xact("w0 lw 8", 1'b0, 32'h8, 32'h0, 3'd2, 32'h55AA55AA, 1'b0, 1);

        // Reset during WAIT drops the pending store.
        sel = 1'b0;
        xact("sw 20",   1'b1, 32'h20, 32'h0BADF00D, 3'd2, 32'h0,        1'b0, 3);
        xact("lw 20",   1'b0, 32'h20, 32'h0,        3'd2, 32'h0BADF00D, 1'b0, 3);
        @(negedge clk);
        drive_req(1'b1, 32'h20, 32'h11111111, 3'd2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid in wait", {30'b0, req_ready_o, resp_valid_o}, 32'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid rst valid", {31'b0, resp_valid_o}, 32'd0);
        check("mid rst rdata", resp_rdata_o, 32'h0);
        check("mid rst err", {31'b0, resp_err_o}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        xact("lw 20 post", 1'b0, 32'h20, 32'h0, 3'd2, 32'h0BADF00D, 1'b0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
